pc_unit: RTL and testbench

Parametrised program-counter unit for the instruction-fetch stage. It holds the architectural PC and advances it sequentially, by 4 or by 2. It accepts trap and branch/jump redirects and buffers a redirect that arrives during a fetch stall. It also flags misaligned redirect targets. It replaces the separate PC register, adder and source-select path with one registered block, and drives the fetch address every cycle.

---
 rtl/pc_unit.sv | 123 ++++++++++++
 tb/tb_pc_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for instruction fetch: sequential advance, trap/redirect
// selection, stalled-redirect buffering and misaligned-target detection.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0200),
  parameter int unsigned     IALIGN       = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            half_step_i,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] badaddr_o
);

  // Address bits that must be zero for a legal fetch target.
  localparam logic [XLEN-1:0] LowMask = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

  typedef enum logic [1:0] {
    StReset,
    StStart,
    StRun
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] badaddr_q, badaddr_d;
  logic            pending_valid_q, pending_valid_d;
  logic [XLEN-1:0] pending_target_q, pending_target_d;

  logic            target_misaligned;
  logic [XLEN-1:0] pc_step;
  logic [XLEN-1:0] trap_target;

  assign target_misaligned = |(redirect_target_i & LowMask);
  assign trap_target       = trap_vector_i & ~LowMask;
  assign pc_step           = ((IALIGN == 16) && half_step_i) ? XLEN'(2) : XLEN'(4);

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    valid_d          = valid_q;
    misaligned_d     = 1'b0;
    badaddr_d        = badaddr_q;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;

    unique case (state_q)
      StReset: begin
        state_d = StStart;
        valid_d = 1'b1;
      end

      // The start cycle presents the reset vector; its closing edge ignores
      // every control input and simply steps to the next word.
      StStart: begin
        state_d = StRun;
        pc_d    = pc_q + XLEN'(4);
      end

      StRun: begin
        if (trap_i) begin
          pc_d            = trap_target;
          pending_valid_d = 1'b0;
        end else if (redirect_i && target_misaligned) begin
          misaligned_d = 1'b1;
          badaddr_d    = redirect_target_i;
        end else if (redirect_i && !if_stall_i) begin
          pc_d            = redirect_target_i;
          pending_valid_d = 1'b0;
        end else if (redirect_i) begin
          pending_valid_d  = 1'b1;
          pending_target_d = redirect_target_i;
        end else if (if_stall_i) begin
          pc_d = pc_q;
        end else if (pending_valid_q) begin
          pc_d            = pending_target_q;
          pending_valid_d = 1'b0;
        end else begin
          pc_d = pc_q + pc_step;
        end
      end

      default: begin
        state_d = StReset;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= StReset;
      pc_q             <= RESET_VECTOR;
      valid_q          <= 1'b0;
      misaligned_q     <= 1'b0;
      badaddr_q        <= '0;
      pending_valid_q  <= 1'b0;
      pending_target_q <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      valid_q          <= valid_d;
      misaligned_q     <= misaligned_d;
      badaddr_q        <= badaddr_d;
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
    end
  end

  assign pc_o         = pc_q;
  assign valid_o      = valid_q;
  assign misaligned_o = misaligned_q;
  assign badaddr_o    = badaddr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit with one 32-bit-aligned and one
// 16-bit-aligned instance.
module tb_pc_unit;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        trap;
    logic [31:0] tvec;
    logic        half;
    logic [31:0] pc;
    logic        valid;
    logic        mis;
    logic [31:0] bad;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, stall_a, redir_a, trap_a, half_a;
  logic [31:0] tgt_a, tvec_a;
  logic [31:0] pc_a, bad_a;
  logic        valid_a, mis_a;

  logic        rst_b, stall_b, redir_b, trap_b, half_b;
  logic [31:0] tgt_b, tvec_b;
  logic [31:0] pc_b, bad_b;
  logic        valid_b, mis_b;

  int errors = 0;
  int checks = 0;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0200), .IALIGN(32)) dut32 (
    .clk_i             (clk),
    .rst_i             (rst_a),
    .if_stall_i        (stall_a),
    .redirect_i        (redir_a),
    .redirect_target_i (tgt_a),
    .trap_i            (trap_a),
    .trap_vector_i     (tvec_a),
    .half_step_i       (half_a),
    .pc_o              (pc_a),
    .valid_o           (valid_a),
    .misaligned_o      (mis_a),
    .badaddr_o         (bad_a)
  );

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0200), .IALIGN(16)) dut16 (
    .clk_i             (clk),
    .rst_i             (rst_b),
    .if_stall_i        (stall_b),
    .redirect_i        (redir_b),
    .redirect_target_i (tgt_b),
    .trap_i            (trap_b),
    .trap_vector_i     (tvec_b),
    .half_step_i       (half_b),
    .pc_o              (pc_b),
    .valid_o           (valid_b),
    .misaligned_o      (mis_b),
    .badaddr_o         (bad_b)
  );

  function automatic vec_t mk(logic rst, logic stall, logic redir, logic [31:0] tgt,
                              logic trap, logic [31:0] tvec, logic half,
                              logic [31:0] pc, logic valid, logic mis, logic [31:0] bad);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.tgt = tgt;
    v.trap = trap; v.tvec = tvec; v.half = half;
    v.pc = pc; v.valid = valid; v.mis = mis; v.bad = bad;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one vector to the selected instance, clock once, compare all outputs.
  task automatic apply(input vec_t v, input bit sel, input int idx);
    if (!sel) begin
      rst_a = v.rst; stall_a = v.stall; redir_a = v.redir; tgt_a = v.tgt;
      trap_a = v.trap; tvec_a = v.tvec; half_a = v.half;
    end else begin
      rst_b = v.rst; stall_b = v.stall; redir_b = v.redir; tgt_b = v.tgt;
      trap_b = v.trap; tvec_b = v.tvec; half_b = v.half;
    end
    @(posedge clk);
    #1;
    if (!sel) begin
      check($sformatf("a%0d pc", idx), pc_a, v.pc);
      check($sformatf("a%0d valid", idx), 32'(valid_a), 32'(v.valid));
      check($sformatf("a%0d mis", idx), 32'(mis_a), 32'(v.mis));
      check($sformatf("a%0d bad", idx), bad_a, v.bad);
    end else begin
      check($sformatf("b%0d pc", idx), pc_b, v.pc);
      check($sformatf("b%0d valid", idx), 32'(valid_b), 32'(v.valid));
      check($sformatf("b%0d mis", idx), 32'(mis_b), 32'(v.mis));
      check($sformatf("b%0d bad", idx), bad_b, v.bad);
    end
  endtask

  vec_t va[$];
  vec_t vb[$];

  initial begin
    rst_a = 1; stall_a = 0; redir_a = 0; tgt_a = 0; trap_a = 0; tvec_a = 0; half_a = 0;
    rst_b = 1; stall_b = 0; redir_b = 0; tgt_b = 0; trap_b = 0; tvec_b = 0; half_b = 0;

    //          rst st rd tgt           tr tvec          hf pc            v  m  bad
    va.push_back(mk(1, 0, 0, 32'h0,      0, 32'h0,      0, 32'h200, 0, 0, 32'h0));
    va.push_back(mk(1, 0, 0, 32'h0,      0, 32'h0,      0, 32'h200, 0, 0, 32'h0));
    va.push_back(mk(0, 1, 1, 32'h444,    1, 32'h999,    0, 32'h200, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h204, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      1, 32'h208, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h20C, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h210, 1, 0, 32'h0));
    // stall three cycles with two buffered redirects; latest wins
    va.push_back(mk(0, 1, 1, 32'h400,    0, 32'h0,      0, 32'h210, 1, 0, 32'h0));
    va.push_back(mk(0, 1, 1, 32'h500,    0, 32'h0,      0, 32'h210, 1, 0, 32'h0));
    va.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,      0, 32'h210, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h500, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h504, 1, 0, 32'h0));
    // trap beats stalled redirect and discards pending
    va.push_back(mk(0, 1, 1, 32'h400,    1, 32'h803,    0, 32'h800, 1, 0, 32'h0));
    va.push_back(mk(0, 1, 0, 32'h0,      0, 32'h0,      0, 32'h800, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h804, 1, 0, 32'h0));
    // misaligned redirect
    va.push_back(mk(0, 0, 1, 32'h300,    0, 32'h0,      0, 32'h300, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 1, 32'h402,    0, 32'h0,      0, 32'h300, 1, 1, 32'h402));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h304, 1, 0, 32'h402));
    // new unstalled redirect beats a pending one
    va.push_back(mk(0, 1, 1, 32'h700,    0, 32'h0,      0, 32'h304, 1, 0, 32'h402));
    va.push_back(mk(0, 0, 1, 32'h720,    0, 32'h0,      0, 32'h720, 1, 0, 32'h402));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h724, 1, 0, 32'h402));
    // reset mid-stall discards pending 0x600
    va.push_back(mk(0, 1, 1, 32'h600,    0, 32'h0,      0, 32'h724, 1, 0, 32'h402));
    va.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,      0, 32'h200, 0, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h200, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h204, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h208, 1, 0, 32'h0));
    // trap with misaligned redirect: no report
    va.push_back(mk(0, 0, 1, 32'h406,    1, 32'h900,    0, 32'h900, 1, 0, 32'h0));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h904, 1, 0, 32'h0));
    // misaligned while stalled keeps existing pending redirect
    va.push_back(mk(0, 1, 1, 32'hA00,    0, 32'h0,      0, 32'h904, 1, 0, 32'h0));
    va.push_back(mk(0, 1, 1, 32'hA01,    0, 32'h0,      0, 32'h904, 1, 1, 32'hA01));
    va.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'hA00, 1, 0, 32'hA01));

    vb.push_back(mk(1, 0, 0, 32'h0,      0, 32'h0,      0, 32'h200, 0, 0, 32'h0));
    vb.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      1, 32'h200, 1, 0, 32'h0));
    vb.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      1, 32'h204, 1, 0, 32'h0));
    vb.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      1, 32'h206, 1, 0, 32'h0));
    vb.push_back(mk(0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0,   0, 32'hFFFF_FFFE, 1, 0, 32'h0));
    vb.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      1, 32'h0,   1, 0, 32'h0));
    vb.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h4,   1, 0, 32'h0));
    vb.push_back(mk(0, 0, 0, 32'h0,      1, 32'h803,    0, 32'h802, 1, 0, 32'h0));
    vb.push_back(mk(0, 0, 1, 32'h403,    0, 32'h0,      0, 32'h802, 1, 1, 32'h403));
    vb.push_back(mk(0, 0, 1, 32'h402,    0, 32'h0,      0, 32'h402, 1, 0, 32'h403));
    vb.push_back(mk(0, 0, 0, 32'h0,      0, 32'h0,      1, 32'h404, 1, 0, 32'h403));

    #2;
    foreach (va[i]) apply(va[i], 1'b0, i);

    // long stall then release, followed by a lone misaligned pulse
    for (int i = 0; i < 5; i++) begin
      apply(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'hA00, 1, 0, 32'hA01), 1'b0, 100 + i);
    end
    apply(mk(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'hA04, 1, 0, 32'hA01), 1'b0, 105);
    apply(mk(0, 0, 1, 32'hB02, 0, 32'h0, 0, 32'hA04, 1, 1, 32'hB02), 1'b0, 106);
    apply(mk(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'hA08, 1, 0, 32'hB02), 1'b0, 107);

    foreach (vb[i]) apply(vb[i], 1'b1, i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
